// File: rtl/uart_tx_driver.sv
// CPU-facing UART transmitter: byte FIFO feeding an 8N1 serializer.
// Status word {overflow, busy, full, empty}; overflow is sticky until a status read.
module uart_tx_driver #(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        iCpuClock,
  input  logic        iCpuReset,
  input  logic        iDoUartWrite,
  input  logic [1:0]  iUartAddress,
  input  logic [15:0] iUartDataToWrite,
  input  logic        iDoUartRead,
  output logic [15:0] oUartDataRead,
  output logic        oUartTx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic [BAUD_W-1:0]  r_baud;
  logic [BAUD_W-1:0]  w_baud_nxt;
  logic [2:0]         r_bit;
  logic [2:0]         w_bit_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               r_tx;
  logic               w_tx_nxt;

  logic w_empty, w_full, w_busy;
  logic w_wr_data, w_push, w_pop, w_drop, w_stat_rd, w_baud_end;
  logic w_unused;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_busy     = (r_state != IDLE);
  assign w_wr_data  = iDoUartWrite && (iUartAddress == 2'd0);
  assign w_push     = w_wr_data && (!w_full || w_pop);
  assign w_drop     = w_wr_data && w_full && !w_pop;
  assign w_stat_rd  = iDoUartRead && (iUartAddress == 2'd1);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_unused   = ^iUartDataToWrite[15:8];

  assign oUartDataRead = w_stat_rd ? {12'b0, r_ovf, w_busy, w_full, w_empty} : 16'h0000;
  assign oUartTx       = r_tx;

  // Next-state logic; the line level is computed for the upcoming state so it can be registered.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_baud_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
    endcase
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // A drop in the same cycle as a clearing read leaves the flag set.
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_stat_rd) r_ovf <= 1'b0;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the control registers above.
  always_ff @(posedge iCpuClock) begin
    if (w_push) r_mem[r_wptr] <= iUartDataToWrite[7:0];
    r_shift <= w_shift_nxt;
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// Directed bench for uart_tx_driver with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A background receiver decodes frames into rx_q for byte-order checks.
module tb_uart_tx_driver;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [8:0] rx_q [$];

  always #5 clk = ~clk;

  uart_tx_driver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .iCpuClock(clk),
    .iCpuReset(rst_n),
    .iDoUartWrite(wr),
    .iUartAddress(addr),
    .iUartDataToWrite(wdata),
    .iDoUartRead(rd),
    .oUartDataRead(rdata),
    .oUartTx(tx)
  );

  // Receiver: sampled 1ns after each edge; frames touched by reset are discarded.
  initial begin
    logic [7:0] b;
    logic       stop;
    logic       aborted;
    forever begin
      @(posedge clk); #1;
      if (rst_n && tx == 1'b0) begin
        aborted = 1'b0;
        b = 8'h00;
        repeat (2) begin @(posedge clk); #1; if (!rst_n) aborted = 1'b1; end
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) begin @(posedge clk); #1; if (!rst_n) aborted = 1'b1; end
          b[j] = tx;
        end
        repeat (CPB) begin @(posedge clk); #1; if (!rst_n) aborted = 1'b1; end
        stop = tx;
        if (!aborted) rx_q.push_back({stop, b});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic wr_byte(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = {8'hC3, d};
    wr    = 1'b1;
    @(posedge clk); #1;
    wr    = 1'b0;
    addr  = 2'd0;
  endtask

  task automatic read_status(output logic [15:0] v);
    rd   = 1'b1;
    addr = 2'd1;
    #1;
    v = rdata;
    @(posedge clk); #1;
    rd   = 1'b0;
    addr = 2'd0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    rd = 1'b1; addr = 2'd1; #1;
    checks++; if (rdata !== 16'h0001) begin errors++; $display("FAIL reset_status: got %h expected 0001", rdata); end
    addr = 2'd0; #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL read_addr0: got %h expected 0000", rdata); end
    rd = 1'b0; addr = 2'd1; #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL no_strobe: got %h expected 0000", rdata); end
    addr = 2'd0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b expected 1", tx); end
  endtask

  task automatic test_single_byte;
    logic [7:0]  b;
    logic        exp;
    logic [15:0] v;
    b = 8'h55;
    rx_q.delete();
    wr_byte(2'd0, b);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_push_edge: got %b expected 1", tx); end
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      if (k <= 4)       exp = 1'b0;
      else if (k <= 36) exp = b[(k - 5) / 4];
      else              exp = 1'b1;
      checks++;
      if (tx !== exp) begin errors++; $display("FAIL single_wave cycle %0d: got %b expected %b", k, tx, exp); end
    end
    read_status(v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL single_status: got %h expected 0001", v); end
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_rx_count: got %0d expected 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 9'h155) begin errors++; $display("FAIL single_rx_byte: got %h expected 155", rx_q[0]); end
    end
  endtask

  task automatic test_burst_overflow;
    logic [15:0] v;
    logic [8:0]  exp;
    rx_q.delete();
    for (int i = 0; i < 6; i++) wr_byte(2'd0, 8'hA1 + 8'(i));
    read_status(v);
    checks++; if (v !== 16'h000E) begin errors++; $display("FAIL burst_status1: got %h expected 000E", v); end
    read_status(v);
    checks++; if (v !== 16'h0006) begin errors++; $display("FAIL burst_status2: got %h expected 0006", v); end
    wait_rx(5, 400);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL burst_rx_count: got %0d expected 5", rx_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        exp = {1'b1, 8'hA1 + 8'(i)};
        checks++;
        if (rx_q[i] !== exp) begin errors++; $display("FAIL burst_rx_byte%0d: got %h expected %h", i, rx_q[i], exp); end
      end
    end
    repeat (60) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL burst_dropped: got %0d frames expected 5", rx_q.size()); end
    read_status(v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL burst_final_status: got %h expected 0001", v); end
  endtask

  task automatic test_mid_frame_reset;
    logic [15:0] v;
    int          hi;
    rx_q.delete();
    wr_byte(2'd0, 8'hF0);
    wr_byte(2'd0, 8'h11);
    wr_byte(2'd0, 8'h22);
    repeat (16) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst_bit3: got %b expected 0", tx); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx_async: got %b expected 1", tx); end
    rd = 1'b1; addr = 2'd1; #1;
    checks++; if (rdata !== 16'h0001) begin errors++; $display("FAIL midrst_status_in_reset: got %h expected 0001", rdata); end
    rd = 1'b0; addr = 2'd0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_status(v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL midrst_status: got %h expected 0001", v); end
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (tx === 1'b1) hi++;
    end
    checks++; if (hi != 100) begin errors++; $display("FAIL midrst_line_high: got %0d high cycles expected 100", hi); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midrst_no_frames: got %0d frames expected 0", rx_q.size()); end
  endtask

  task automatic test_ignored_access;
    logic [15:0] v;
    int          lo;
    rx_q.delete();
    wr_byte(2'd1, 8'h33);
    wr_byte(2'd2, 8'h44);
    wr_byte(2'd3, 8'h66);
    addr = 2'd0; wdata = 16'h0077; wr = 1'b0;
    @(posedge clk); #1;
    lo = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lo++;
    end
    checks++; if (lo != 0) begin errors++; $display("FAIL ignored_no_start: got %0d low cycles expected 0", lo); end
    read_status(v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL ignored_status: got %h expected 0001", v); end
  endtask

  task automatic test_collision;
    logic [15:0] v;
    logic [8:0]  exp;
    rx_q.delete();
    for (int i = 0; i < 5; i++) wr_byte(2'd0, 8'hB1 + 8'(i));
    addr = 2'd0; wdata = 16'h00EE; wr = 1'b1; rd = 1'b1;
    #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL coll_read_value: got %h expected 0000", rdata); end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    read_status(v);
    checks++; if (v !== 16'h000E) begin errors++; $display("FAIL coll_ovf_set: got %h expected 000E", v); end
    read_status(v);
    checks++; if (v !== 16'h0006) begin errors++; $display("FAIL coll_ovf_cleared: got %h expected 0006", v); end
    wait_rx(5, 400);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL coll_rx_count: got %0d expected 5", rx_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        exp = {1'b1, 8'hB1 + 8'(i)};
        checks++;
        if (rx_q[i] !== exp) begin errors++; $display("FAIL coll_rx_byte%0d: got %h expected %h", i, rx_q[i], exp); end
      end
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int n;
    rx_q.delete();
    wr_byte(2'd0, 8'h00);
    wr_byte(2'd0, 8'hFF);
    n = 0;
    while (tx === 1'b0 && n < 100) begin n++; @(posedge clk); #1; end
    checks++; if (n != 36) begin errors++; $display("FAIL b2b_first_low: got %0d cycles expected 36", n); end
    n = 0;
    while (tx === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
    checks++; if (n != 5) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected 5", n); end
    n = 0;
    while (tx === 1'b0 && n < 100) begin n++; @(posedge clk); #1; end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_second_start: got %0d cycles expected 4", n); end
    wait_rx(2, 100);
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL b2b_rx_count: got %0d expected 2", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 9'h100) begin errors++; $display("FAIL b2b_rx0: got %h expected 100", rx_q[0]); end
      checks++; if (rx_q[1] !== 9'h1FF) begin errors++; $display("FAIL b2b_rx1: got %h expected 1FF", rx_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_overflow();
    test_mid_frame_reset();
    test_ignored_access();
    test_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_driver.md
UART_TX_DRIVER -- requirements
Module: uart_tx_driver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 200: iCpuClock cycles per UART bit; legal values are 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; legal values are powers of two, 2 or more.
REQ-003 SHALL have port iCpuClock  in  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iCpuReset  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port iDoUartWrite  in  1: CPU write strobe; one write per high cycle.
REQ-006 SHALL have port iUartAddress  in  2: 0 = TX data, 1 = status; 2 and 3 are reserved.
REQ-007 SHALL have port iUartDataToWrite  in  16: bits [7:0] are the byte; bits [15:8] are ignored.
REQ-008 SHALL have port iDoUartRead  in  1: CPU read strobe.
REQ-009 SHALL have port oUartDataRead  out  16: status word.
REQ-010 SHALL have port oUartTx  out  1: serial line, wired to Minisys_Uart_ToPc.

Function
REQ-011 SHALL push iUartDataToWrite[7:0] into the FIFO at a rising edge when iDoUartWrite=1, iUartAddress=0, and (FIFO not full, or a pop occurs at the same edge).
REQ-012 SHALL drop any data write that finds the FIFO full with no pop at the same edge, and SHALL set the sticky overflow flag at that edge.
REQ-013 SHALL ignore writes to addresses 1..3; these have no effect on any state.
REQ-014 SHALL drive oUartDataRead combinationally as {12'b0, overflow, busy, full, empty} when iDoUartRead=1 and iUartAddress=1, and as 16'h0000 otherwise.
REQ-015 SHALL clear overflow at the edge ending a status read; if a set occurs at the same edge, the set wins.
REQ-016 SHALL define empty as count==0, full as count==FIFO_DEPTH, and busy as state!=IDLE; count has range 0..FIFO_DEPTH.
REQ-017 SHALL use FIFO read and write pointers that wrap modulo FIFO_DEPTH, and SHALL deliver bytes in FIFO order.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: oUartTx=1; if the FIFO is not empty at an edge, SHALL pop the head into the shift register, clear the baud counter, and enter START.
REQ-020 START: oUartTx=0 for CLKS_PER_BIT cycles, then SHALL enter DATA with the bit index at 0.
REQ-021 DATA: oUartTx=shift[0] (LSB first); each bit SHALL be held CLKS_PER_BIT cycles; after bit 7 the FSM SHALL enter STOP.
REQ-022 STOP: oUartTx=1 for CLKS_PER_BIT cycles, then SHALL return to IDLE.
REQ-023 Frame format SHALL be 8N1, totalling exactly 10*CLKS_PER_BIT cycles from START entry to IDLE entry.
REQ-024 Back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-025 Latency: a byte pushed into an empty FIFO while in IDLE at edge N SHALL be popped at edge N+1; oUartTx SHALL go low after edge N+1.
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-027 oUartTx SHALL be driven from a register, with no combinational glitches.

Reset
REQ-028 While iCpuReset=0, the block SHALL immediately hold: oUartTx=1, state IDLE, count=0, pointers=0, overflow=0, baud counter=0, bit index=0, oUartDataRead per REQ-014.
REQ-029 A reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; after release no partial frame SHALL resume.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Single byte: write 0x55 to addr 0 after reset -> oUartTx low cycles 1-4 after the push edge, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; line idle after 40 cycles; status 0x0001.
REQ-031 Burst overflow: six writes A1..A6 on consecutive cycles from IDLE -> A1..A5 are transmitted in order and A6 is dropped; a status read right after the burst returns 0x000E (overflow, busy, full); the next read returns 0x0006.
REQ-032 Mid-frame reset: assert reset during data bit 3 of 0xF0 with 2 bytes queued -> oUartTx=1 immediately; after release status is 0x0001 and the line stays high for 100 cycles.
REQ-033 Ignored accesses: write 0x33 to addr 1, and present data to addr 0 with iDoUartWrite=0 -> no start bit within 50 cycles; status 0x0001.
REQ-034 Set/clear collision: with FIFO full, a dropped write and a status read at the same edge -> the read returns overflow=0; the next read returns overflow=1.
REQ-035 Back-to-back: write 0x00 then 0xFF -> exactly one high cycle between the first STOP bit and the second START bit, i.e. a 5-cycle high gap.
